// File: rtl/sound_mem_arbiter.sv
// Shares one SDRAM client port between posted GLU sound-RAM writes and DOC5503 wave-fetch reads.
// Optional dropped-write statistics counter is enabled by defining SOUND_MEM_ARB_STATS_EN.
module sound_mem_arbiter #(
   parameter int ADDR_W    = 21,
   parameter int WFIFO_D   = 4,
   parameter int RD_STREAK = 8
) (
   input  logic              clk_logic,
   input  logic              system_reset,
   input  logic              glu_wr_i,
   input  logic [ADDR_W-1:0] glu_addr_i,
   input  logic [31:0]       glu_data_i,
   input  logic [3:0]        glu_byte_en_i,
   input  logic              doc_rd_i,
   input  logic [ADDR_W-1:0] doc_addr_i,
   output logic              doc_ready_o,
   output logic [31:0]       doc_q_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   output logic [3:0]        mem_byte_en_o,
   input  logic              mem_ready_i,
   input  logic [31:0]       mem_q_i,
   output logic              wr_overflow_o,
   output logic              rd_overflow_o,
   output logic [15:0]       dropped_wr_cnt_o
);

   localparam int PTR_W = (WFIFO_D > 1) ? $clog2(WFIFO_D) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int STK_W = $clog2(RD_STREAK + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;

   logic [1:0]        state;
   logic [STK_W-1:0]  streak;

   logic              slot_vld;
   logic [ADDR_W-1:0] slot_addr;

   logic [ADDR_W-1:0] fifo_addr [WFIFO_D];
   logic [31:0]       fifo_data [WFIFO_D];
   logic [3:0]        fifo_be   [WFIFO_D];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;

   logic fifo_empty;
   logic fifo_full;
   logic rd_issue;
   logic wr_issue;
   logic push_ok;
   logic wr_drop;
   logic slot_load;
   logic rd_drop;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(WFIFO_D));

   // Reads win unless a write has waited through RD_STREAK consecutive read grants.
   assign rd_issue = (state == IDLE) && slot_vld &&
                     (fifo_empty || (streak < STK_W'(RD_STREAK)));
   assign wr_issue = (state == IDLE) && !fifo_empty &&
                     (!slot_vld || (streak == STK_W'(RD_STREAK)));

   // A pop in the same cycle frees a slot for a push into a full FIFO.
   assign push_ok   = glu_wr_i && (!fifo_full || wr_issue);
   assign wr_drop   = glu_wr_i && fifo_full && !wr_issue;
   assign slot_load = doc_rd_i && !slot_vld;
   assign rd_drop   = doc_rd_i && slot_vld;

   // FIFO storage carries data only; occupancy lives in the control block below.
   always_ff @(posedge clk_logic) begin
      if (push_ok) begin
         fifo_addr[wr_ptr] <= glu_addr_i;
         fifo_data[wr_ptr] <= glu_data_i;
         fifo_be[wr_ptr]   <= glu_byte_en_i;
      end
      if (slot_load) begin
         slot_addr <= doc_addr_i;
      end
   end

   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         slot_vld      <= 1'b0;
         wr_overflow_o <= 1'b0;
         rd_overflow_o <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (wr_issue) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, wr_issue})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (rd_issue) begin
            slot_vld <= 1'b0;
         end else if (slot_load) begin
            slot_vld <= 1'b1;
         end
         if (wr_drop) begin
            wr_overflow_o <= 1'b1;
         end
         if (rd_drop) begin
            rd_overflow_o <= 1'b1;
         end
      end
   end

   // Command FSM: one outstanding command, address/data held until completion.
   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         state         <= IDLE;
         streak        <= '0;
         mem_rd_o      <= 1'b0;
         mem_wr_o      <= 1'b0;
         mem_addr_o    <= '0;
         mem_data_o    <= '0;
         mem_byte_en_o <= '0;
         doc_ready_o   <= 1'b0;
         doc_q_o       <= '0;
      end else begin
         mem_rd_o    <= 1'b0;
         mem_wr_o    <= 1'b0;
         doc_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_issue) begin
                  mem_rd_o      <= 1'b1;
                  mem_addr_o    <= slot_addr;
                  mem_byte_en_o <= 4'hF;
                  state         <= RD_WAIT;
                  streak        <= fifo_empty ? '0 : streak + STK_W'(1);
               end else if (wr_issue) begin
                  mem_wr_o      <= 1'b1;
                  mem_addr_o    <= fifo_addr[rd_ptr];
                  mem_data_o    <= fifo_data[rd_ptr];
                  mem_byte_en_o <= fifo_be[rd_ptr];
                  state         <= WR_WAIT;
                  streak        <= '0;
               end
            end
            RD_WAIT: begin
               if (mem_ready_i) begin
                  doc_q_o     <= mem_q_i;
                  doc_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            WR_WAIT: begin
               if (mem_ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOUND_MEM_ARB_STATS_EN
   logic [15:0] drop_cnt;

   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         drop_cnt <= '0;
      end else if (wr_drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign dropped_wr_cnt_o = drop_cnt;
`else
   assign dropped_wr_cnt_o = 16'h0;
`endif

endmodule
